csr_machine: RTL and testbench
==============================

CSR_MACHINE -- requirements
Module: csr_machine

Interface
REQ-001 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-002 SHALL have parameter VECTORED, default 1; 1 enables mtvec vectored mode, 0 hardwires mtvec[1:0]=0.
REQ-003 SHALL have parameter CNT_WIDTH, default 64, range 33..64; implemented width of mcycle/minstret; bits above CNT_WIDTH read 0.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- number  in  12  CSR address
- access_type  in  2  CSR_READ_ONLY / CSR_WRITE / CSR_SET / CSR_CLEAR (shared csr.h encodings)
- in  in  32  write operand
- out  out  32  current CSR value (combinational)
- illegal  out  1  access is illegal (combinational)
- retire  in  1  one instruction retired this cycle
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  mcause value (bit31=interrupt)
- trap_pc  in  32  PC to save in mepc
- trap_tval  in  32  value for mtval
- mret  in  1  execute MRET this cycle
- irq_ext, irq_timer, irq_soft  in  1 each  interrupt lines, level-sensitive
- trap_vector  out  32  redirect target on trap
- epc  out  32  mepc, used as MRET target
- irq_pending  out  1  enabled interrupt pending

Function
REQ-005 SHALL implement misa (0x301, 0x40000100), mvendorid/marchid/mimpid (0), mhartid (HART_ID), mstatus (0x300), mie (0x304), mip (0x344), mtvec (0x305), mscratch (0x340), mepc (0x341), mcause (0x342), mtval (0x343), mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82).
REQ-006 SHALL form the write value as: WRITE -> in; SET -> current|in; CLEAR -> current&~in; READ_ONLY -> no write.
REQ-007 mstatus SHALL hold MIE (bit3), MPIE (bit7); MPP (bits12:11) SHALL read 2'b11; other bits read 0 and ignore writes.
REQ-008 mie SHALL hold MEIE/MTIE/MSIE (bits 11/7/3); mip SHALL read {irq_ext,irq_timer,irq_soft} at bits 11/7/3 sampled one cycle earlier and ignore writes.
REQ-009 mepc bits[1:0] SHALL always read 0; mtvec bits[1:0]: 0 or 1 writable when VECTORED=1, values 2/3 stored as 0.
REQ-010 mcycle SHALL increment every cycle; minstret SHALL increment when retire=1; low word wraps 0xFFFFFFFF->0 with carry into high word; full counter wraps to 0.
REQ-011 A CSR write to a counter word SHALL take precedence over that cycle's increment of the whole counter.
REQ-012 illegal SHALL be 1 for an unimplemented number, or a non-READ_ONLY access to number[11:10]==2'b11; illegal accesses SHALL not modify state.
REQ-013 On trap_valid: mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0, all next edge.
REQ-014 On mret (trap_valid=0): MIE<=MPIE, MPIE<=1.
REQ-015 Priority SHALL be trap_valid > mret > CSR write; a lower-priority CSR write to a register changed by the higher event is dropped; counters still advance.
REQ-016 trap_vector SHALL be {mtvec[31:2],2'b00}, plus 4*trap_cause[30:0] when mode=1 and trap_cause[31]=1.
REQ-017 irq_pending SHALL equal MIE & |(mie & mip), combinational from registered state.
REQ-018 out SHALL reflect pre-edge values (read-before-write within a cycle).

Reset
REQ-019 On reset SHALL clear mstatus MIE/MPIE, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret to 0.
REQ-020 Reset SHALL override trap_valid, mret, retire and CSR writes in the same cycle; out, epc, trap_vector read 0-derived values next cycle.

Structure
REQ-021 CSR address constants, mstatus/mie bit positions and cause codes SHALL live in a shared package csr_pkg; access_type encodings stay in csr.h.
REQ-022 The 64-bit split counter SHALL be a sub-module csr_counter (CNT_WIDTH, inc, lo/hi write ports), instantiated twice.

Verification
REQ-023 Reset, 10 idle cycles, read mcycle -> 10; mcycleh -> 0; minstret -> 0.
REQ-024 Write mcycle=0xFFFFFFFF, next cycle read mcycleh -> 1, mcycle -> 0.
REQ-025 mtvec=0x1001, trap_cause=0x80000007 -> trap_vector 0x101C; trap_cause=2 -> 0x1000.
REQ-026 MIE=1, trap_valid with trap_pc=0x203 -> mepc reads 0x200, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
REQ-027 mie=0x80, MIE=1, irq_timer=1 -> irq_pending=1 two cycles later; CLEAR mstatus 0x8 -> irq_pending 0.
REQ-028 WRITE to 0xF11 -> illegal=1, no state change; READ 0x7C0 -> illegal=1, out=0.

Source files
------------

// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses, field bit positions and trap cause codes
// shared by the CSR block and anything that needs to decode CSR numbers.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // misa: RV32, I extension only
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // mstatus field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  // mie / mip field positions
  localparam int MIE_MSIE_BIT = 3;
  localparam int MIE_MTIE_BIT = 7;
  localparam int MIE_MEIE_BIT = 11;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // mcause values
  localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'h0000_0000;
  localparam logic [31:0] CAUSE_ILLEGAL_INSTR    = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAKPOINT       = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M          = 32'h0000_000B;
  localparam logic [31:0] CAUSE_MSI              = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI              = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI              = 32'h8000_000B;

  // mtvec mode field
  typedef enum logic [1:0] {
    TVEC_DIRECT   = 2'b00,
    TVEC_VECTORED = 2'b01
  } tvec_mode_e;

  // True for every CSR number this block answers to
  function automatic logic csr_implemented(input logic [11:0] num);
    case (num)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID,
      CSR_MHARTID: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_machine_counter.sv
// Split 32/32 performance counter with independent low/high word writes.
// A word write replaces that word and suppresses the whole increment for
// the cycle, so software sees exactly the value it wrote.
module csr_counter
  import csr_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        lo_we,
  input  logic [31:0] lo_wdata,
  input  logic        hi_we,
  input  logic [31:0] hi_wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] count;
  logic [63:0]          count_ext;

  // Word writes win over the increment; otherwise count up with natural wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (lo_we || hi_we) begin
      if (lo_we) count[31:0] <= lo_wdata;
      if (hi_we) count[CNT_WIDTH-1:32] <= hi_wdata[HI_W-1:0];
    end else if (inc) begin
      count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count_ext = 64'(count);
  assign lo        = count_ext[31:0];
  assign hi        = count_ext[63:32];

endmodule

// File: rtl/csr_machine.sv
// Machine-mode CSR file: trap entry/return bookkeeping, interrupt
// enables and pending status, trap vector generation and the
// mcycle/minstret counters.
module csr_machine
  import csr_pkg::*;
#(
  parameter int HART_ID   = 0,
  parameter int VECTORED  = 1,
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] number,
  input  logic [1:0]  access_type,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        illegal,
  input  logic        retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  output logic [31:0] trap_vector,
  output logic [31:0] epc,
  output logic        irq_pending
);

  // Access encodings shared with csr.h
  localparam logic [1:0] CSR_READ_ONLY = 2'd0;
  localparam logic [1:0] CSR_WRITE     = 2'd1;
  localparam logic [1:0] CSR_SET       = 2'd2;
  localparam logic [1:0] CSR_CLEAR     = 2'd3;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_q;
  logic        irq_ext_q;
  logic        irq_timer_q;
  logic        irq_soft_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  logic [31:0] mcycle_lo;
  logic [31:0] mcycle_hi;
  logic [31:0] minstret_lo;
  logic [31:0] minstret_hi;

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] write_value;
  logic        write_en;
  logic [1:0]  mtvec_mode;

  // Assemble the architectural views of mstatus and mip from their stored bits
  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie;
    mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie;
    mip_val = '0;
    mip_val[MIE_MEIE_BIT] = irq_ext_q;
    mip_val[MIE_MTIE_BIT] = irq_timer_q;
    mip_val[MIE_MSIE_BIT] = irq_soft_q;
  end

  // Read mux: pre-edge register values, zero for unimplemented numbers
  always_comb begin
    out = '0;
    case (number)
      CSR_MSTATUS:   out = mstatus_val;
      CSR_MISA:      out = MISA_VALUE;
      CSR_MIE:       out = mie_q;
      CSR_MTVEC:     out = mtvec_q;
      CSR_MSCRATCH:  out = mscratch_q;
      CSR_MEPC:      out = mepc_q;
      CSR_MCAUSE:    out = mcause_q;
      CSR_MTVAL:     out = mtval_q;
      CSR_MIP:       out = mip_val;
      CSR_MCYCLE:    out = mcycle_lo;
      CSR_MCYCLEH:   out = mcycle_hi;
      CSR_MINSTRET:  out = minstret_lo;
      CSR_MINSTRETH: out = minstret_hi;
      CSR_MVENDORID: out = '0;
      CSR_MARCHID:   out = '0;
      CSR_MIMPID:    out = '0;
      CSR_MHARTID:   out = 32'(HART_ID);
      default:       out = '0;
    endcase
  end

  assign illegal = !csr_implemented(number) ||
                   ((access_type != CSR_READ_ONLY) && (number[11:10] == 2'b11));
  assign write_en = (access_type != CSR_READ_ONLY) && !illegal;

  // Read-modify-write value for the selected access kind
  always_comb begin
    write_value = out;
    case (access_type)
      CSR_WRITE: write_value = in;
      CSR_SET:   write_value = out | in;
      CSR_CLEAR: write_value = out & ~in;
      default:   write_value = out;
    endcase
    mtvec_mode = ((VECTORED != 0) && (write_value[1:0] == TVEC_VECTORED)) ?
                 TVEC_VECTORED : TVEC_DIRECT;
  end

  // CSR writes first, then trap/mret overwrite the registers they own,
  // which drops any same-cycle software write to those registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      irq_ext_q    <= 1'b0;
      irq_timer_q  <= 1'b0;
      irq_soft_q   <= 1'b0;
      mtvec_q      <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      irq_ext_q   <= irq_ext;
      irq_timer_q <= irq_timer;
      irq_soft_q  <= irq_soft;
      if (write_en) begin
        case (number)
          CSR_MSTATUS: begin
            mstatus_mie  <= write_value[MSTATUS_MIE_BIT];
            mstatus_mpie <= write_value[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      mie_q      <= write_value & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= {write_value[31:2], mtvec_mode};
          CSR_MSCRATCH: mscratch_q <= write_value;
          CSR_MEPC:     mepc_q     <= write_value & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= write_value;
          CSR_MTVAL:    mtval_q    <= write_value;
          default: ;
        endcase
      end
      if (trap_valid) begin
        mepc_q       <= trap_pc & ~32'h3;
        mcause_q     <= trap_cause;
        mtval_q      <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk      (clk),
    .reset    (reset),
    .inc      (1'b1),
    .lo_we    (write_en && (number == CSR_MCYCLE)),
    .lo_wdata (write_value),
    .hi_we    (write_en && (number == CSR_MCYCLEH)),
    .hi_wdata (write_value),
    .lo       (mcycle_lo),
    .hi       (mcycle_hi)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk      (clk),
    .reset    (reset),
    .inc      (retire),
    .lo_we    (write_en && (number == CSR_MINSTRET)),
    .lo_wdata (write_value),
    .hi_we    (write_en && (number == CSR_MINSTRETH)),
    .hi_wdata (write_value),
    .lo       (minstret_lo),
    .hi       (minstret_hi)
  );

  // Trap target: base address, offset by cause for vectored interrupts
  always_comb begin
    trap_vector = {mtvec_q[31:2], 2'b00};
    if ((mtvec_q[1:0] == TVEC_VECTORED) && trap_cause[31])
      trap_vector = trap_vector + {trap_cause[29:0], 2'b00};
  end

  assign epc         = mepc_q;
  assign irq_pending = mstatus_mie && |(mie_q & mip_val);

endmodule

// File: tb/tb_csr_machine.sv
// Directed and randomized checks of csr_machine against a behavioural
// model of the machine-mode CSR rules.
module tb_csr_machine;

  localparam logic [1:0] ACC_READ  = 2'd0;
  localparam logic [1:0] ACC_WRITE = 2'd1;
  localparam logic [1:0] ACC_SET   = 2'd2;
  localparam logic [1:0] ACC_CLEAR = 2'd3;
  localparam int TB_HART = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] number;
  logic [1:0]  access_type;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        illegal;
  logic        retire;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic        irq_ext;
  logic        irq_timer;
  logic        irq_soft;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic        irq_pending;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit              m_mie_bit;
  bit              m_mpie;
  logic [31:0]     m_mie;
  logic [31:0]     m_mtvec;
  logic [31:0]     m_mscratch;
  logic [31:0]     m_mepc;
  logic [31:0]     m_mcause;
  logic [31:0]     m_mtval;
  bit              m_ext;
  bit              m_timer;
  bit              m_soft;
  longint unsigned m_cycle;
  longint unsigned m_instret;

  logic [11:0] addr_pool [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                  12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                  12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12,
                                  12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'hC00};

  always #5 clk = ~clk;

  csr_machine #(.HART_ID(TB_HART), .VECTORED(1), .CNT_WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .number      (number),
    .access_type (access_type),
    .in          (in_data),
    .out         (out_data),
    .illegal     (illegal),
    .retire      (retire),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret        (mret),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .irq_soft    (irq_soft),
    .trap_vector (trap_vector),
    .epc         (epc),
    .irq_pending (irq_pending)
  );

  function automatic bit model_implemented(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                     12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
  endfunction

  function automatic bit model_illegal(input logic [11:0] a, input logic [1:0] acc);
    return !model_implemented(a) || (acc != ACC_READ && a >= 12'hC00);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie_bit ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (m_ext ? 32'h800 : 32'h0) + (m_timer ? 32'h80 : 32'h0) + (m_soft ? 32'h8 : 32'h0);
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return TB_HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_vector();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if ((m_mtvec & 32'h3) == 32'h1 && trap_cause[31])
      base = base + 32'd4 * (trap_cause & 32'h7FFF_FFFF);
    return base;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    #1;
    checkOutput("out", out_data, model_read(number));
    checkOutput("illegal", 32'(illegal), 32'(model_illegal(number, access_type)));
    checkOutput("trap_vector", trap_vector, model_vector());
    checkOutput("epc", epc, m_mepc);
    checkOutput("irq_pending", 32'(irq_pending),
                32'(m_mie_bit && ((m_mie & model_read(12'h344)) != 0)));
  endtask

  task automatic applyStimulus(input logic [11:0] num, input logic [1:0] acc,
                               input logic [31:0] data);
    number      = num;
    access_type = acc;
    in_data     = data;
    trap_valid  = 1'b0;
    mret        = 1'b0;
  endtask

  // Predict next state from the current inputs, clock the DUT, then commit
  task automatic tick();
    logic [31:0] w;
    bit we;
    bit n_mie_bit, n_mpie, n_ext, n_timer, n_soft;
    logic [31:0] n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
    longint unsigned n_cycle, n_instret;
    if (reset) begin
      n_mie_bit = 0; n_mpie = 0; n_ext = 0; n_timer = 0; n_soft = 0;
      n_mie = 0; n_mtvec = 0; n_mscratch = 0; n_mepc = 0; n_mcause = 0; n_mtval = 0;
      n_cycle = 0; n_instret = 0;
    end else begin
      n_mie_bit = m_mie_bit; n_mpie = m_mpie;
      n_ext = irq_ext; n_timer = irq_timer; n_soft = irq_soft;
      n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
      n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
      case (access_type)
        ACC_WRITE: w = in_data;
        ACC_SET:   w = model_read(number) | in_data;
        ACC_CLEAR: w = model_read(number) & ~in_data;
        default:   w = model_read(number);
      endcase
      we = access_type != ACC_READ && !model_illegal(number, access_type);
      n_cycle   = m_cycle + 1;
      n_instret = m_instret + (retire ? 1 : 0);
      if (we) begin
        case (number)
          12'h300: begin n_mie_bit = w[3]; n_mpie = w[7]; end
          12'h304: n_mie = w & 32'h888;
          12'h305: n_mtvec = (w & ~32'h3) | (((w & 32'h3) == 32'h1) ? 32'h1 : 32'h0);
          12'h340: n_mscratch = w;
          12'h341: n_mepc = w & ~32'h3;
          12'h342: n_mcause = w;
          12'h343: n_mtval = w;
          12'hB00: n_cycle = {m_cycle[63:32], w};
          12'hB80: n_cycle = {w, m_cycle[31:0]};
          12'hB02: n_instret = {m_instret[63:32], w};
          12'hB82: n_instret = {w, m_instret[31:0]};
          default: ;
        endcase
      end
      if (trap_valid) begin
        n_mepc = trap_pc & ~32'h3;
        n_mcause = trap_cause;
        n_mtval = trap_tval;
        n_mpie = m_mie_bit;
        n_mie_bit = 0;
      end else if (mret) begin
        n_mie_bit = m_mpie;
        n_mpie = 1;
      end
    end
    @(posedge clk);
    #1;
    m_mie_bit = n_mie_bit; m_mpie = n_mpie;
    m_ext = n_ext; m_timer = n_timer; m_soft = n_soft;
    m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
    m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
    m_cycle = n_cycle; m_instret = n_instret;
  endtask

  initial begin
    reset = 1'b1;
    retire = 1'b0;
    trap_cause = 32'h0;
    trap_pc = 32'h0;
    trap_tval = 32'h0;
    irq_ext = 1'b0;
    irq_timer = 1'b0;
    irq_soft = 1'b0;
    applyStimulus(12'h300, ACC_READ, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    checkAll();
    checkOutput("reset_mstatus", out_data, 32'h1800);

    // Ten idle cycles after reset
    for (int i = 0; i < 10; i++) tick();
    applyStimulus(12'hB00, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mcycle_10", out_data, 32'd10);
    applyStimulus(12'hB80, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mcycleh_0", out_data, 32'd0);
    applyStimulus(12'hB02, ACC_READ, 32'h0);
    checkAll();
    checkOutput("minstret_0", out_data, 32'd0);

    // Low-word carry into the high word
    applyStimulus(12'hB00, ACC_WRITE, 32'hFFFF_FFFF);
    checkAll();
    tick();
    applyStimulus(12'hB00, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mcycle_written", out_data, 32'hFFFF_FFFF);
    tick();
    applyStimulus(12'hB80, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mcycleh_carry", out_data, 32'd1);
    tick();
    applyStimulus(12'hB00, ACC_READ, 32'h0);
    checkAll();

    // Vectored trap target
    applyStimulus(12'h305, ACC_WRITE, 32'h1001);
    tick();
    applyStimulus(12'h305, ACC_READ, 32'h0);
    trap_cause = 32'h8000_0007;
    checkAll();
    checkOutput("vector_irq", trap_vector, 32'h101C);
    trap_cause = 32'h2;
    checkAll();
    checkOutput("vector_exc", trap_vector, 32'h1000);

    // Trap entry and MRET
    applyStimulus(12'h300, ACC_SET, 32'h8);
    tick();
    applyStimulus(12'h300, ACC_READ, 32'h0);
    trap_valid = 1'b1;
    trap_pc = 32'h203;
    trap_tval = 32'hDEAD_BEEF;
    tick();
    applyStimulus(12'h341, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mepc_aligned", out_data, 32'h200);
    applyStimulus(12'h300, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mstatus_trap", out_data, 32'h1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checkAll();
    checkOutput("mstatus_mret", out_data, 32'h1888);

    // Timer interrupt pending path
    applyStimulus(12'h304, ACC_WRITE, 32'h80);
    tick();
    applyStimulus(12'h300, ACC_READ, 32'h0);
    irq_timer = 1'b1;
    tick();
    tick();
    checkAll();
    checkOutput("irq_pending_on", 32'(irq_pending), 32'd1);
    applyStimulus(12'h300, ACC_CLEAR, 32'h8);
    tick();
    applyStimulus(12'h300, ACC_READ, 32'h0);
    checkAll();
    checkOutput("irq_pending_off", 32'(irq_pending), 32'd0);
    irq_timer = 1'b0;

    // Illegal accesses
    applyStimulus(12'hF11, ACC_WRITE, 32'h1234);
    checkAll();
    checkOutput("illegal_ro_write", 32'(illegal), 32'd1);
    tick();
    applyStimulus(12'h7C0, ACC_READ, 32'h0);
    checkAll();
    checkOutput("illegal_unimpl", 32'(illegal), 32'd1);
    checkOutput("unimpl_out", out_data, 32'd0);
    applyStimulus(12'hF14, ACC_READ, 32'h0);
    checkAll();

    // Trap vs concurrent software writes
    applyStimulus(12'h340, ACC_WRITE, 32'hCAFE);
    trap_valid = 1'b1;
    trap_pc = 32'h400;
    tick();
    applyStimulus(12'h340, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mscratch_with_trap", out_data, 32'hCAFE);
    applyStimulus(12'h341, ACC_WRITE, 32'h444);
    trap_valid = 1'b1;
    trap_pc = 32'h808;
    tick();
    applyStimulus(12'h341, ACC_READ, 32'h0);
    checkAll();
    checkOutput("mepc_trap_wins", out_data, 32'h808);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(addr_pool[$urandom_range(0, 19)], 2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 2) == 0) in_data = in_data & 32'h0000_0FFF;
      trap_valid = ($urandom_range(0, 15) == 0);
      mret       = ($urandom_range(0, 11) == 0);
      retire     = $urandom_range(0, 1) == 1;
      trap_cause = $urandom;
      trap_pc    = $urandom;
      trap_tval  = $urandom;
      irq_ext    = $urandom_range(0, 3) == 0;
      irq_timer  = $urandom_range(0, 3) == 0;
      irq_soft   = $urandom_range(0, 3) == 0;
      reset      = ($urandom_range(0, 99) == 0);
      checkAll();
      tick();
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
